// File: rtl/ksa_engine.sv
// ksa_engine: RC4 key-scheduling engine driving an external single-port S memory.
//
// On an accepted start the engine writes the identity permutation into S, then
// runs the RC4 key-scheduling swap pass over every entry, issuing all accesses
// through the same address/data/wren/q port the S memory exposes.
//
// Parameters
//   DATA_W     S-memory data and address width; the memory has 2**DATA_W entries.
//   KEY_BYTES  secret key length in bytes.
//
// Ports
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   start       start request, honoured only when idle or done
//   secret_key  key, byte 0 in the most significant byte; latched on acceptance
//   address     RAM address (registered)
//   data        RAM write data (registered)
//   wren        RAM write enable (registered)
//   q           RAM read data
//   busy        high while the schedule is in progress
//   done        high after completion until the next accepted start
//
// Build option
//   KSA_OUTREG_EN  target a RAM with registered q (2-cycle read latency); a wait
//                  state follows each read-address state. Undefined: 1-cycle RAM.
//
// Output timing: the registered outputs always describe the state the FSM is in,
// so every output register is loaded from the next-state decision. The first
// INIT cycle after acceptance issues nothing; the INIT writes 0..DEPTH-1 appear
// in the following DEPTH cycles.

module ksa_engine #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [KEY_BYTES*8-1:0] secret_key,
    output logic [DATA_W-1:0]      address,
    output logic [DATA_W-1:0]      data,
    output logic                   wren,
    input  logic [DATA_W-1:0]      q,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned KidxW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    localparam logic [DATA_W-1:0] LastIdx = {DATA_W{1'b1}};
    localparam logic [KidxW-1:0]  LastKey = KidxW'(KEY_BYTES - 1);

    localparam logic [3:0] StIdle = 4'd0;
    localparam logic [3:0] StInit = 4'd1;
    localparam logic [3:0] StRdi  = 4'd2;
    localparam logic [3:0] StLdi  = 4'd4;
    localparam logic [3:0] StRdj  = 4'd5;
    localparam logic [3:0] StLdj  = 4'd7;
    localparam logic [3:0] StWri  = 4'd8;
    localparam logic [3:0] StWrj  = 4'd9;
    localparam logic [3:0] StDone = 4'd10;
`ifdef KSA_OUTREG_EN
    localparam logic [3:0] StWti  = 4'd3;
    localparam logic [3:0] StWtj  = 4'd6;
`endif

    logic [3:0]             state_q, state_d;
    logic [DATA_W-1:0]      i_q, i_d;
    logic [DATA_W-1:0]      j_q, j_d;
    logic [KidxW-1:0]       kidx_q, kidx_d;
    logic [DATA_W-1:0]      si_q, si_d;
    logic [KEY_BYTES*8-1:0] key_q, key_d;
    logic                   wrap_q, wrap_d;
    logic [DATA_W-1:0]      address_q, address_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic                   wren_q, wren_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [7:0]             key_byte;
    logic [DATA_W-1:0]      j_next;

    // Key byte selected by the wrapping key index; a plain mux, no division.
    always_comb begin
        key_byte = 8'h00;
        for (int unsigned b = 0; b < KEY_BYTES; b++) begin
            if (kidx_q == KidxW'(b)) begin
                key_byte = key_q[(KEY_BYTES - 1 - b) * 8 +: 8];
            end
        end
    end

    // The key byte is truncated or zero-extended to DATA_W; the sum wraps.
    assign j_next = j_q + q + DATA_W'(key_byte);

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        kidx_d    = kidx_q;
        si_d      = si_q;
        key_d     = key_q;
        wrap_d    = wrap_q;
        address_d = address_q;
        data_d    = data_q;
        wren_d    = 1'b0;
        busy_d    = busy_q;
        done_d    = done_q;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    key_d     = secret_key;
                    i_d       = '0;
                    j_d       = '0;
                    kidx_d    = '0;
                    wrap_d    = 1'b0;
                    address_d = '0;
                    data_d    = '0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    state_d   = StInit;
                end
            end

            StInit: begin
                if (!wrap_q) begin
                    // Write S[i] = i; after the last entry i has wrapped to 0.
                    address_d = i_q;
                    data_d    = i_q;
                    wren_d    = 1'b1;
                    i_d       = i_q + 1'b1;
                    if (i_q == LastIdx) begin
                        wrap_d = 1'b1;
                    end
                end else begin
                    // Last write is on the bus this cycle; move on to reading S[0].
                    wrap_d    = 1'b0;
                    address_d = i_q;
                    state_d   = StRdi;
                end
            end

            StRdi: begin
`ifdef KSA_OUTREG_EN
                state_d = StWti;
`else
                state_d = StLdi;
`endif
            end

`ifdef KSA_OUTREG_EN
            StWti: begin
                state_d = StLdi;
            end
`endif

            StLdi: begin
                si_d      = q;
                j_d       = j_next;
                kidx_d    = (kidx_q == LastKey) ? '0 : kidx_q + 1'b1;
                address_d = j_next;
                state_d   = StRdj;
            end

            StRdj: begin
`ifdef KSA_OUTREG_EN
                state_d = StWtj;
`else
                state_d = StLdj;
`endif
            end

`ifdef KSA_OUTREG_EN
            StWtj: begin
                state_d = StLdj;
            end
`endif

            StLdj: begin
                // S[j] goes straight into the write-data register for S[i].
                address_d = i_q;
                data_d    = q;
                wren_d    = 1'b1;
                state_d   = StWri;
            end

            StWri: begin
                address_d = j_q;
                data_d    = si_q;
                wren_d    = 1'b1;
                state_d   = StWrj;
            end

            StWrj: begin
                if (i_q == LastIdx) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    i_d       = i_q + 1'b1;
                    address_d = i_q + 1'b1;
                    state_d   = StRdi;
                end
            end

            default: begin
                busy_d  = 1'b0;
                done_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            i_q       <= '0;
            j_q       <= '0;
            kidx_q    <= '0;
            si_q      <= '0;
            key_q     <= '0;
            wrap_q    <= 1'b0;
            address_q <= '0;
            data_q    <= '0;
            wren_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            kidx_q    <= kidx_d;
            si_q      <= si_d;
            key_q     <= key_d;
            wrap_q    <= wrap_d;
            address_q <= address_d;
            data_q    <= data_d;
            wren_q    <= wren_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign address = address_q;
    assign data    = data_q;
    assign wren    = wren_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_ksa_engine.sv
// Bench for ksa_engine: a DATA_W=2/KEY_BYTES=1 instance and a DATA_W=8/KEY_BYTES=3
// instance, each attached to a behavioural RAM whose read latency follows
// KSA_OUTREG_EN. Final S contents are compared against a plain RC4 KSA model.

module tb_ksa_engine;

    localparam int SD = 4;
    localparam int BD = 256;
`ifdef KSA_OUTREG_EN
    localparam int RdLat   = 2;
    localparam int IterCyc = 8;
`else
    localparam int RdLat   = 1;
    localparam int IterCyc = 6;
`endif
    localparam int SmallDone = (1 + IterCyc) * SD + 1;
    localparam int BigDone   = (1 + IterCyc) * BD + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Small instance
    logic       rst_s, start_s, wren_s, busy_s, done_s;
    logic [7:0] key_s;
    logic [1:0] addr_s, data_s, q_s;

    ksa_engine #(.DATA_W(2), .KEY_BYTES(1)) dut_s (
        .clk        (clk),
        .reset_n    (rst_s),
        .start      (start_s),
        .secret_key (key_s),
        .address    (addr_s),
        .data       (data_s),
        .wren       (wren_s),
        .q          (q_s),
        .busy       (busy_s),
        .done       (done_s)
    );

    // Big instance
    logic        rst_b, start_b, wren_b, busy_b, done_b;
    logic [23:0] key_b;
    logic [7:0]  addr_b, data_b, q_b;

    ksa_engine #(.DATA_W(8), .KEY_BYTES(3)) dut_b (
        .clk        (clk),
        .reset_n    (rst_b),
        .start      (start_b),
        .secret_key (key_b),
        .address    (addr_b),
        .data       (data_b),
        .wren       (wren_b),
        .q          (q_b),
        .busy       (busy_b),
        .done       (done_b)
    );

    // RAM models: address registered at the edge, q one cycle later (or two).
    logic [1:0] mem_s [SD];
    logic [1:0] ra_s, qr_s;
    int         wr_s = 0;
    always @(posedge clk) begin
        if (wren_s) begin
            mem_s[addr_s] <= data_s;
            wr_s          <= wr_s + 1;
        end
        ra_s <= addr_s;
        qr_s <= mem_s[ra_s];
    end
    assign q_s = (RdLat == 2) ? qr_s : mem_s[ra_s];

    logic [7:0] mem_b [BD];
    logic [7:0] ra_b, qr_b;
    always @(posedge clk) begin
        if (wren_b) mem_b[addr_b] <= data_b;
        ra_b <= addr_b;
        qr_b <= mem_b[ra_b];
    end
    assign q_b = (RdLat == 2) ? qr_b : mem_b[ra_b];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference RC4 KSA, straight from the algorithm definition.
    int ref_s [BD];
    function automatic void ksa_ref(input int depth, input int nbytes, input logic [23:0] key);
        int j, t, kb;
        for (int i = 0; i < depth; i++) ref_s[i] = i;
        j = 0;
        for (int i = 0; i < depth; i++) begin
            kb = int'((key >> (8 * (nbytes - 1 - (i % nbytes)))) & 24'hff);
            j  = (j + ref_s[i] + kb) % depth;
            t  = ref_s[i];
            ref_s[i] = ref_s[j];
            ref_s[j] = t;
        end
    endfunction

    function automatic int s_mismatch(input bit big);
        int m = 0;
        if (big) begin
            for (int i = 0; i < BD; i++) if (int'(mem_b[i]) != ref_s[i]) m++;
        end else begin
            for (int i = 0; i < SD; i++) if (int'(mem_s[i]) != ref_s[i]) m++;
        end
        return m;
    endfunction

    // Present start for one edge; returns #1 after the accepting edge.
    task automatic kick(input bit big, input logic [23:0] key);
        @(negedge clk);
        if (big) begin
            key_b   = key;
            start_b = 1'b1;
        end else begin
            key_s   = key[7:0];
            start_s = 1'b1;
        end
        @(posedge clk);
        #1;
        start_b = 1'b0;
        start_s = 1'b0;
    endtask

    // Edges after acceptance until done is seen; -1 if the budget runs out.
    task automatic wait_done(input bit big, input bit disturb, input logic [23:0] alt_key,
                             output int lat);
        int limit;
        limit = big ? BigDone + 50 : SmallDone + 20;
        lat   = -1;
        for (int n = 1; n <= limit; n++) begin
            @(posedge clk);
            #1;
            if (disturb) begin
                if (n == 5) key_b = alt_key;
                start_b = (n == 300 || n == 1000);
            end
            if (big ? done_b : done_s) begin
                lat = n;
                break;
            end
        end
        start_b = 1'b0;
    endtask

    typedef struct {
        logic [7:0] key;
        int         s0, s1, s2, s3;
    } vec_t;

    vec_t        vecs [5];
    int          lat, w0, exp_p, act_p;
    logic [23:0] k;

    initial begin
        vecs[0] = '{8'h01, 0, 2, 3, 1};
        vecs[1] = '{8'h00, 0, 2, 3, 1};  // self-swaps at i=0 and i=1
        vecs[2] = '{8'h02, 2, 0, 3, 1};
        vecs[3] = '{8'h03, 1, 0, 3, 2};
        vecs[4] = '{8'h05, 0, 2, 3, 1};  // key byte wraps to DATA_W bits

        rst_s = 1'b0; rst_b = 1'b0; start_s = 1'b0; start_b = 1'b0;
        key_s = '0;   key_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_address", longint'(addr_b), 0);
        check("rst_data", longint'(data_b), 0);
        check("rst_wren", longint'(wren_b), 0);
        check("rst_busy", longint'(busy_b), 0);
        check("rst_done", longint'(done_b), 0);
        check("rst_small_outs", longint'({addr_s, data_s, wren_s, busy_s, done_s}), 0);
        @(negedge clk);
        rst_s = 1'b1;
        rst_b = 1'b1;

        // Small instance: fixed vectors
        for (int v = 0; v < 5; v++) begin
            kick(1'b0, {16'h0, vecs[v].key});
            w0 = wr_s;
            check($sformatf("small_busy_k%0h", vecs[v].key), longint'(busy_s), 1);
            wait_done(1'b0, 1'b0, 24'h0, lat);
            check($sformatf("small_done_edge_k%0h", vecs[v].key), lat, SmallDone);
            exp_p = (vecs[v].s3 << 6) | (vecs[v].s2 << 4) | (vecs[v].s1 << 2) | vecs[v].s0;
            act_p = int'({mem_s[3], mem_s[2], mem_s[1], mem_s[0]});
            check($sformatf("small_s_k%0h", vecs[v].key), act_p, exp_p);
            check($sformatf("small_writes_k%0h", vecs[v].key), wr_s - w0, 12);
            check($sformatf("small_busy_end_k%0h", vecs[v].key), longint'(busy_s), 0);
        end

        // Small instance: random keys against the model
        for (int r = 0; r < 6; r++) begin
            k = {16'h0, 8'($urandom_range(0, 255))};
            ksa_ref(SD, 1, k);
            kick(1'b0, k);
            wait_done(1'b0, 1'b0, 24'h0, lat);
            check($sformatf("small_rand_lat_k%0h", k), lat, SmallDone);
            check($sformatf("small_rand_s_k%0h", k), s_mismatch(1'b0), 0);
        end

        // Big instance: reference key
        ksa_ref(BD, 3, 24'h000249);
        kick(1'b1, 24'h000249);
        wait_done(1'b1, 1'b0, 24'h0, lat);
        check("big_done_edge_000249", lat, BigDone);
        check("big_s_000249", s_mismatch(1'b1), 0);
        check("big_busy_at_done", longint'(busy_b), 0);

        // Reset in the middle of INIT
        kick(1'b1, 24'h123456);
        repeat (50) @(posedge clk);
        #1;
        check("midinit_busy", longint'(busy_b), 1);
        check("midinit_wren", longint'(wren_b), 1);
        #2;
        rst_b = 1'b0;
        #1;
        check("midinit_rst_address", longint'(addr_b), 0);
        check("midinit_rst_data", longint'(data_b), 0);
        check("midinit_rst_wren", longint'(wren_b), 0);
        check("midinit_rst_busy", longint'(busy_b), 0);
        check("midinit_rst_done", longint'(done_b), 0);
        @(negedge clk);
        rst_b = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_idle", longint'({busy_b, done_b, wren_b}), 0);

        // Disturbed run: extra start pulses and a key change after acceptance
        k = 24'($urandom);
        ksa_ref(BD, 3, k);
        kick(1'b1, k);
        wait_done(1'b1, 1'b1, ~k, lat);
        check("disturb_done_edge", lat, BigDone);
        check("disturb_s", s_mismatch(1'b1), 0);

        // Reset during the shuffle at i=100, then a clean restart
        k = 24'($urandom);
        kick(1'b1, k);
        repeat (BD + 1 + IterCyc * 100 + 2) @(posedge clk);
        #3;
        rst_b = 1'b0;
        #1;
        check("midshuf_rst_outs", longint'({addr_b, data_b, wren_b, busy_b, done_b}), 0);
        @(negedge clk);
        rst_b = 1'b1;
        ksa_ref(BD, 3, k);
        kick(1'b1, k);
        wait_done(1'b1, 1'b0, 24'h0, lat);
        check("restart_done_edge", lat, BigDone);
        check("restart_s", s_mismatch(1'b1), 0);

        // Big instance: random keys
        for (int r = 0; r < 2; r++) begin
            k = 24'($urandom);
            ksa_ref(BD, 3, k);
            kick(1'b1, k);
            wait_done(1'b1, 1'b0, 24'h0, lat);
            check($sformatf("big_rand_lat_k%0h", k), lat, BigDone);
            check($sformatf("big_rand_s_k%0h", k), s_mismatch(1'b1), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ksa_engine.md
# ksa_engine

Parametrised RC4 key-scheduling engine for the decryptor datapath. On a start request it fills the external S memory with the identity permutation, then runs the full key-scheduling swap pass, driving the same single-port RAM interface (address, data, wren, q) that the S memory exposes. It generalises the array initialiser with configurable memory depth and key length, a start/busy/done handshake, and the read-modify-swap phase.

## Interface
- DATA_W, default 8: S-memory data and address width; DEPTH = 2**DATA_W entries.
- KEY_BYTES, default 3: secret key length in bytes.
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE or DONE.
- secret_key  in  KEY_BYTES*8  key; byte 0 = secret_key[KEY_BYTES*8-1 -: 8] (MSB-first); captured when start is accepted.
- address  out  DATA_W  RAM address, registered.
- data  out  DATA_W  RAM write data, registered.
- wren  out  1  RAM write enable, registered.
- q  in  DATA_W  RAM read data.
- busy  out  1  high from the cycle after start acceptance until done rises.
- done  out  1  level; high in DONE until the next accepted start.

## Operation
- States: IDLE, INIT, RDI, (WTI), LDI, RDJ, (WTJ), LDJ, WRI, WRJ, DONE. WTI/WTJ exist only with KSA_OUTREG_EN.
- IDLE/DONE + start=1: capture key, i=0, j=0, go to INIT.
- INIT: address=i, data=i, wren=1; i increments each cycle; after i=DEPTH-1, i=0 and go to RDI.
- RDI: address=i, wren=0. LDI: si<=q; j <= (j + q + key[i mod KEY_BYTES]) mod DEPTH.
- RDJ: address=j. LDJ: sj<=q.
- WRI: address=i, data=sj, wren=1. WRJ: address=j, data=si, wren=1.
- After WRJ: if i=DEPTH-1, go to DONE; else i++ and go to RDI.
- All arithmetic is DATA_W-bit with wrap-around. The key index counter wraps at KEY_BYTES independently of i; it uses no division.
- i==j: both writes hit the same address with the same value. No special handling.
- start while busy is ignored. secret_key changes after acceptance have no effect.
- reset_n low at any time: immediate return to IDLE. address=0, data=0, wren=0, busy=0, done=0, i=j=0. The S contents are left partially updated, and a restart fully reinitialises them.

## Timing
- The RAM registers address on the rising edge, and q is valid in the following cycle. This is why RDx is followed by LDx.
- Start accepted at edge E0. INIT occupies cycles 1..DEPTH.
- Each shuffle iteration takes 6 cycles, or 8 with KSA_OUTREG_EN.
- done and busy update at the edge ending the last WRJ:
  - done=1 and busy=0 at E0 + 7*DEPTH + 1 edges (1793 for DEPTH=256).
  - With KSA_OUTREG_EN: E0 + 9*DEPTH + 1 edges (2305 for DEPTH=256).
- wren is high only in INIT, WRI and WRJ.

## Configuration
- KSA_OUTREG_EN defined: targets a RAM with a registered q (2-cycle read latency). One wait state is inserted after each of RDI and RDJ.
- KSA_OUTREG_EN undefined: targets a 1-cycle read-latency RAM with no wait states.

## Test plan
- Reset: assert reset_n=0 mid-INIT -> address, data, wren, busy and done all read 0 within the same cycle; FSM returns to IDLE.
- DATA_W=2, KEY_BYTES=1, key 8'h01, 1-cycle RAM model: start -> S reads [0,2,3,1]; done rises 29 edges after acceptance; exactly 4 INIT writes plus 8 swap writes.
- DATA_W=2, key 8'h00 (covers the i==j self-swap at i=0 and i=1): start -> S reads [0,2,3,1] with no corrupted entries.
- DATA_W=8, KEY_BYTES=3, key 24'h000249: start -> final S matches a software RC4 KSA model byte-for-byte; done at edge 1793.
- Pulse start during the shuffle, and change secret_key after acceptance -> result and completion time are identical to an undisturbed run.
- Reset mid-shuffle (i=100), then start again -> result identical to a clean run.
- With KSA_OUTREG_EN and a 2-cycle RAM model: key 24'h000249 -> same final S as above; done at edge 2305.
